mips32_mem_arbiter: RTL and testbench

MIPS32_MEM_ARBITER -- requirements
Module: mips32_mem_arbiter

---
 rtl/mips32_pkg.sv | 18 +
 rtl/mips32_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 memory arbiter: state encoding,
// default address width and the starvation-counter helper.
package mips32_pkg;

    localparam int unsigned ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_DM = 2'd2
    } arb_state_e;

    // Saturating increment used by the fetch starvation counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic [7:0] lim);
        return (val >= lim) ? lim : val + 8'd1;
    endfunction

endpackage

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter between the pipe_MIPS32 IF and MEM stages.
// Data accesses win unless a waiting fetch has been passed over STARVE_MAX times.
module mips32_mem_arbiter
    import mips32_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk1,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,

    input  logic              halted,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    arb_state_e  state_q, state_d;
    logic [7:0]  starve_q, starve_d;
    logic        if_rvalid_q, dm_rvalid_q;
    logic [31:0] if_rdata_q, dm_rdata_q;

    logic              fetch_ok;
    logic              fetch_forced;
    logic              if_win;
    logic              dm_win;
    logic              mem_en_w;
    logic              mem_we_w;
    logic [ADDR_W-1:0] mem_addr_w;
    logic [31:0]       mem_wdata_w;

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        if_win       = 1'b0;
        dm_win       = 1'b0;
        mem_en_w     = 1'b0;
        mem_we_w     = 1'b0;
        mem_addr_w   = '0;
        mem_wdata_w  = '0;
        fetch_ok     = if_req && !halted;
        fetch_forced = fetch_ok && (starve_q == STARVE_LIM);

        unique case (state_q)
            IDLE: begin
                if (dm_req && !fetch_forced) begin
                    dm_win      = 1'b1;
                    mem_en_w    = 1'b1;
                    mem_we_w    = dm_we;
                    mem_addr_w  = dm_addr;
                    mem_wdata_w = dm_wdata;
                    state_d     = dm_we ? IDLE : RD_DM;
                end else if (fetch_ok) begin
                    if_win     = 1'b1;
                    mem_en_w   = 1'b1;
                    mem_addr_w = if_addr;
                    state_d    = RD_IF;
                end
            end
            RD_IF, RD_DM: state_d = IDLE;
            default:      state_d = IDLE;
        endcase

        // A halted fetch neither ages nor clears the counter while if_req stays high.
        if (!if_req || if_win) begin
            starve_d = '0;
        end else if (dm_win && !halted) begin
            starve_d = sat_inc(starve_q, STARVE_LIM);
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            if_rvalid_q <= (state_q == RD_IF);
            dm_rvalid_q <= (state_q == RD_DM);
            if (state_q == RD_IF) begin
                if_rdata_q <= mem_rdata;
            end
            if (state_q == RD_DM) begin
                dm_rdata_q <= mem_rdata;
            end
        end
    end

    // Grant-cycle outputs are combinational, so they are masked directly while reset is high.
    assign if_gnt    = if_win   && !reset;
    assign dm_gnt    = dm_win   && !reset;
    assign mem_en    = mem_en_w && !reset;
    assign mem_we    = mem_we_w && !reset;
    assign mem_addr  = mem_addr_w;
    assign mem_wdata = mem_wdata_w;

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rvalid = dm_rvalid_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter with a 1024-word synchronous memory model.
module tb_mips32_mem_arbiter;

    localparam int unsigned AW = 10;

    logic          clk1 = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [31:0]   if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [31:0]   dm_wdata = '0;
    logic          dm_gnt, dm_rvalid;
    logic [31:0]   dm_rdata;
    logic          halted = 1'b0;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0]   mem [0:1023];

    int checks   = 0;
    int failures = 0;

    mips32_mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(3)) dut (
        .clk1(clk1), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .halted(halted),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    // {if_gnt, dm_gnt, mem_en, mem_we}
    function automatic logic [3:0] gv();
        return {if_gnt, dm_gnt, mem_en, mem_we};
    endfunction

    task automatic test_reset();
        if_req = 1'b1; dm_req = 1'b1; dm_addr = 10'd200;
        @(posedge clk1);
        @(negedge clk1); #1;
        checks++;
        if ({gv(), if_rvalid, dm_rvalid} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000", {gv(), if_rvalid, dm_rvalid});
        end
        checks++;
        if ({if_rdata, dm_rdata} !== 64'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=0", {if_rdata, dm_rdata});
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk1); reset = 1'b0;
        @(negedge clk1);
    endtask

    task automatic test_dm_read();
        @(negedge clk1); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd200; #1;
        checks++;
        if (gv() !== 4'b0110 || mem_addr !== 10'd200) begin
            failures++;
            $display("FAIL dmrd_grant got=%b/%0d exp=0110/200", gv(), mem_addr);
        end
        @(negedge clk1); dm_req = 1'b0; #1;
        checks++;
        if ({gv(), dm_rvalid} !== 5'b0) begin
            failures++;
            $display("FAIL dmrd_n1 got=%b exp=00000", {gv(), dm_rvalid});
        end
        @(negedge clk1); #1;
        checks++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== 32'd7) begin
            failures++;
            $display("FAIL dmrd_n2 got=%b/%0d exp=1/7", dm_rvalid, dm_rdata);
        end
        @(negedge clk1); #1;
        checks++;
        if (dm_rvalid !== 1'b0 || dm_rdata !== 32'd7) begin
            failures++;
            $display("FAIL dmrd_hold got=%b/%0d exp=0/7", dm_rvalid, dm_rdata);
        end
    endtask

    task automatic test_both_req();
        @(negedge clk1);
        if_req = 1'b1; if_addr = 10'd5;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd200; #1;
        checks++;
        if (gv() !== 4'b0110) begin
            failures++;
            $display("FAIL both_n got=%b exp=0110", gv());
        end
        @(negedge clk1); dm_req = 1'b0; #1;
        checks++;
        if (gv() !== 4'b0000) begin
            failures++;
            $display("FAIL both_n1 got=%b exp=0000", gv());
        end
        @(negedge clk1); #1;
        checks++;
        if (gv() !== 4'b1010 || mem_addr !== 10'd5 || dm_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL both_n2 got=%b/%0d/%b exp=1010/5/1", gv(), mem_addr, dm_rvalid);
        end
        @(negedge clk1); if_req = 1'b0; #1;
        checks++;
        if (gv() !== 4'b0000 || if_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL both_n3 got=%b/%b exp=0000/0", gv(), if_rvalid);
        end
        @(negedge clk1); #1;
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hAAAA0005) begin
            failures++;
            $display("FAIL both_ifrd got=%b/%h exp=1/aaaa0005", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_starve();
        logic [3:0] exp;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk1);
            if_req = 1'b1; if_addr = 10'd40;
            dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'(300 + i); dm_wdata = 32'(i); #1;
            exp = (i < 3) ? 4'b0111 : 4'b1010;
            checks++;
            if (gv() !== exp) begin
                failures++;
                $display("FAIL starve_arb%0d got=%b exp=%b", i, gv(), exp);
            end
        end
        @(negedge clk1); if_req = 1'b0; #1;
        checks++;
        if (gv() !== 4'b0000) begin
            failures++;
            $display("FAIL starve_rdif got=%b exp=0000", gv());
        end
        @(negedge clk1); #1;
        checks++;
        if (gv() !== 4'b0111 || if_rvalid !== 1'b1 || if_rdata !== 32'h12340040) begin
            failures++;
            $display("FAIL starve_resume got=%b/%b/%h exp=0111/1/12340040", gv(), if_rvalid, if_rdata);
        end
        @(negedge clk1); dm_req = 1'b0; #1;
        checks++;
        if (gv() !== 4'b0000) begin
            failures++;
            $display("FAIL starve_idle got=%b exp=0000", gv());
        end
    endtask

    task automatic test_write_read();
        @(negedge clk1);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd198; dm_wdata = 32'd5040; #1;
        checks++;
        if (gv() !== 4'b0111 || mem_addr !== 10'd198 || mem_wdata !== 32'd5040) begin
            failures++;
            $display("FAIL wr_grant got=%b/%0d/%0d exp=0111/198/5040", gv(), mem_addr, mem_wdata);
        end
        @(negedge clk1); dm_we = 1'b0; #1;
        checks++;
        if (gv() !== 4'b0110 || dm_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rd_after_wr got=%b/%b exp=0110/0", gv(), dm_rvalid);
        end
        @(negedge clk1); dm_req = 1'b0; #1;
        @(negedge clk1); #1;
        checks++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== 32'd5040) begin
            failures++;
            $display("FAIL rd_198 got=%b/%0d exp=1/5040", dm_rvalid, dm_rdata);
        end
    endtask

    task automatic test_halted();
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk1);
            halted = 1'b1; if_req = 1'b1; if_addr = 10'd40;
            dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'(400 + i); dm_wdata = 32'(i); #1;
            if (gv() !== 4'b0111) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL halt_serve bad_cycles=%0d exp=0", bad);
        end
        @(negedge clk1); dm_req = 1'b0; #1;
        checks++;
        if (gv() !== 4'b0000) begin
            failures++;
            $display("FAIL halt_noif got=%b exp=0000", gv());
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk1); halted = 1'b0; dm_req = 1'b1; #1;
            checks++;
            if (gv() !== ((i < 3) ? 4'b0111 : 4'b1010)) begin
                failures++;
                $display("FAIL unhalt_arb%0d got=%b exp=%b", i, gv(), (i < 3) ? 4'b0111 : 4'b1010);
            end
        end
        @(negedge clk1); if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk1); if_req = 1'b1; if_addr = 10'd5; #1;
        checks++;
        if (gv() !== 4'b1010) begin
            failures++;
            $display("FAIL rst_if_grant got=%b exp=1010", gv());
        end
        @(negedge clk1); #1;
        reset = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd200; #1;
        checks++;
        if ({gv(), if_rvalid, dm_rvalid} !== 6'b0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid got=%b/%h/%h exp=000000/0/0", {gv(), if_rvalid, dm_rvalid}, if_rdata, dm_rdata);
        end
        @(negedge clk1); reset = 1'b0; if_req = 1'b0; #1;
        checks++;
        if (gv() !== 4'b0110 || if_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rst_idle got=%b/%b exp=0110/0", gv(), if_rvalid);
        end
        @(negedge clk1); dm_req = 1'b0; #1;
        checks++;
        if (if_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rst_noifv got=%b exp=0", if_rvalid);
        end
        @(negedge clk1); #1;
        checks++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== 32'd7) begin
            failures++;
            $display("FAIL rst_dmrd got=%b/%0d exp=1/7", dm_rvalid, dm_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD0000 | 32'(i);
        mem[200] = 32'd7;
        mem[5]   = 32'hAAAA0005;
        mem[40]  = 32'h12340040;
        mem_rdata = '0;

        test_reset();
        test_dm_read();
        test_both_req();
        test_starve();
        test_write_read();
        test_halted();
        test_reset_mid_read();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
